// File: rtl/serial_shift_right.sv
// Multi-cycle right shifter (SRL/SRA) with a START/BUSY/DONE handshake.
// Define SHIFT_BY_TWO_EN to retire two bit positions per clock while cnt >= 2.
module serial_shift_right #(
    parameter int unsigned SHIFT_UNIT_WIDTH = 32,
    parameter int unsigned SHAMT_WIDTH      = $clog2(SHIFT_UNIT_WIDTH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic [SHIFT_UNIT_WIDTH-1:0] IN,
    input  logic [SHAMT_WIDTH-1:0]      SHAMT,
    input  logic                        ARITH,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [SHIFT_UNIT_WIDTH-1:0] OUT
);

    localparam int unsigned MSB = SHIFT_UNIT_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   fill;

    // BUSY/DONE are registered alongside state so they always equal its decode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            OUT   <= '0;
            cnt   <= '0;
            fill  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (START) begin
                        OUT  <= IN;
                        cnt  <= SHAMT;
                        fill <= ARITH & IN[MSB];
                        if (SHAMT != '0) begin
                            state <= SHIFT;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                        end else begin
                            state <= FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b0;
                    end
                end
                SHIFT: begin
`ifdef SHIFT_BY_TWO_EN
                    if (cnt >= SHAMT_WIDTH'(2)) begin
                        OUT <= {fill, fill, OUT[MSB:2]};
                        cnt <= cnt - SHAMT_WIDTH'(2);
                        if (cnt == SHAMT_WIDTH'(2)) begin
                            state <= FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        // odd remainder: final single-bit step
                        OUT   <= {fill, OUT[MSB:1]};
                        cnt   <= cnt - SHAMT_WIDTH'(1);
                        state <= FINISH;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
`else
                    OUT <= {fill, OUT[MSB:1]};
                    cnt <= cnt - SHAMT_WIDTH'(1);
                    if (cnt == SHAMT_WIDTH'(1)) begin
                        state <= FINISH;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_right.sv
// Self-checking bench for serial_shift_right: vector table plus hand sequences
// for ignored START, mid-shift reset and back-to-back operation.
module tb_serial_shift_right;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int total  = 0;
    int passed = 0;

    serial_shift_right dut (
        .CLK  (clk),
        .RST  (rst),
        .START(start),
        .IN   (din),
        .SHAMT(shamt),
        .ARITH(arith),
        .BUSY (busy),
        .DONE (done),
        .OUT  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_val;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic int exp_lat(input int sh);
`ifdef SHIFT_BY_TWO_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    // Call at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
    task automatic start_op(input logic [31:0] v, input logic [4:0] s, input logic a);
        start = 1'b1;
        din   = v;
        shamt = s;
        arith = a;
        @(negedge clk);
        start = 1'b0;
        din   = ~v;
        shamt = ~s;
        arith = ~a;
    endtask

    // Counts cycles until DONE (cycle 1 = first cycle after the accept edge).
    task automatic wait_done(output int lat, output int bcyc);
        lat  = 1;
        bcyc = 0;
        while (!done && lat <= 100) begin
            if (busy) bcyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcyc, dones, busies;
        logic [31:0] held;

        vecs[0]  = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
        vecs[1]  = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
        vecs[2]  = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
        vecs[3]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[4]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[5]  = '{32'hFFFF_FFE0, 5'd5,  1'b1, 32'hFFFF_FFFF};
        vecs[6]  = '{32'hFFFF_FFE0, 5'd5,  1'b0, 32'h07FF_FFFF};
        vecs[7]  = '{32'h0000_00F0, 5'd4,  1'b0, 32'h0000_000F};
        vecs[8]  = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF};
        vecs[9]  = '{32'hA5A5_A5A5, 5'd16, 1'b1, 32'hFFFF_A5A5};
        vecs[10] = '{32'hA5A5_A5A5, 5'd3,  1'b0, 32'h14B4_B4B4};

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out",  dout, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].in_val, vecs[i].sh, vecs[i].ar);
            wait_done(lat, bcyc);
            check($sformatf("v%0d_out", i), dout, vecs[i].exp_out);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(int'(vecs[i].sh))));
            check($sformatf("v%0d_busy", i), 32'(bcyc), 32'(exp_lat(int'(vecs[i].sh)) - 1));
            held = dout;
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {30'h0, busy, done}, 32'h0);
            check($sformatf("v%0d_hold", i), dout, held);
        end

        // START re-pulsed during SHIFT must be ignored
        start_op(32'h8000_0000, 5'd31, 1'b1);
        lat = 1;
        while (!done && lat <= 100) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                start = 1'b1;
                din   = 32'h0;
                shamt = 5'd3;
                arith = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ign_lat", 32'(lat), 32'(exp_lat(31)));
        check("ign_out", dout, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a shift
        start_op(32'hDEAD_BEEF, 5'd8, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out",  dout, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        dones  = 0;
        busies = 0;
        repeat (12) begin
            if (done) dones++;
            if (busy) busies++;
            @(negedge clk);
        end
        check("rst_no_done", 32'(dones), 32'h0);
        check("rst_no_busy", 32'(busies), 32'h0);
        start_op(32'h0000_00F0, 5'd4, 1'b0);
        wait_done(lat, bcyc);
        check("post_rst_out", dout, 32'h0000_000F);
        @(negedge clk);

        // Back-to-back: new START accepted in the DONE cycle
        start_op(32'hFFFF_FFE0, 5'd5, 1'b1);
        wait_done(lat, bcyc);
        check("b2b_first_lat", 32'(lat), 32'(exp_lat(5)));
        check("b2b_first_out", dout, 32'hFFFF_FFFF);
        start_op(32'h0000_0002, 5'd1, 1'b0);
        wait_done(lat, bcyc);
        check("b2b_second_lat", 32'(lat), 32'd2);
        check("b2b_second_out", dout, 32'h0000_0001);
        @(negedge clk);
        check("b2b_idle", {30'h0, busy, done}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
